// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg : register map, CTRL bits, state encoding, STATUS packing
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package capture_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DECIM  = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_FORCE = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURING = 2'd2,
        ST_DONE      = 2'd3
    } cap_state_t;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_DONE_BIT  = 2;
    localparam int STATUS_COUNT_LSB = 16;

    function automatic logic [31:0] pack_status(input cap_state_t st,
                                                input logic       done,
                                                input logic [15:0] count);
        logic [31:0] word;
        word = 32'd0;
        word[STATUS_STATE_LSB +: 2]  = st;
        word[STATUS_DONE_BIT]        = done;
        word[STATUS_COUNT_LSB +: 16] = count;
        return word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_capture_ram.sv
// ---------------------------------------------------------------------------
// sample_capture_ram : simple dual-port RAM, sync write, registered sync read
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_capture_ram #(
    parameter int WIDTH      = 17,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/sample_capture_wb_slave.sv
// ---------------------------------------------------------------------------
// sample_capture_wb_slave : Wishbone-readable snapshot buffer for sample stream
// Option macro SAMPLE_CAPTURE_TRIGGER_EN enables rising-zero-crossing trigger.
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_capture_wb_slave
    import capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 17,
    parameter int DEPTH_LOG2   = 10,
    parameter int DECIM_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [1:0]              i_wb_addr,
    input  logic [31:0]             i_wb_data,
    output logic                    o_wb_ack,
    output logic                    o_wb_stall,
    output logic [31:0]             o_wb_data,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_sample_valid,
    output logic                    o_busy,
    output logic                    o_irq
);

    localparam int COUNT_WIDTH = DEPTH_LOG2 + 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = {1'b0, {DEPTH_LOG2{1'b1}}};

    cap_state_t state;
    cap_state_t state_next;

    logic [COUNT_WIDTH-1:0]  count;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DECIM_WIDTH-1:0]  decim_reg;
    logic [DECIM_WIDTH-1:0]  decim_latched;
    logic [DECIM_WIDTH-1:0]  decim_cnt;
    logic [SAMPLE_WIDTH-1:0] ram_q;

    logic accept;
    logic wr_ctrl;
    logic ctrl_arm;
    logic ctrl_abort;
    logic rd_data_req;
    logic trigger_hit;
    logic sample_taken;
    logic store;
    logic last_store;
    logic unused_bits;

    assign accept      = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign wr_ctrl     = accept && i_wb_we && (i_wb_addr == ADDR_CTRL);
    assign ctrl_abort  = wr_ctrl && i_wb_data[CTRL_ABORT];
    assign ctrl_arm    = wr_ctrl && i_wb_data[CTRL_ARM] && !i_wb_data[CTRL_ABORT];
    assign rd_data_req = accept && !i_wb_we && (i_wb_addr == ADDR_DATA);
    assign unused_bits = &{1'b0, i_wb_data};

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    logic prev_neg;
    logic ctrl_force;

    assign ctrl_force  = wr_ctrl && i_wb_data[CTRL_FORCE] &&
                         !i_wb_data[CTRL_ARM] && !i_wb_data[CTRL_ABORT];
    assign trigger_hit = (state == ST_ARMED) && i_sample_valid && prev_neg &&
                         !i_sample[SAMPLE_WIDTH-1];

    // Previous-sample sign tracked only while waiting; ARM resets it to "non-negative".
    always_ff @(posedge i_clk) begin
        if (i_reset || ctrl_arm) begin
            prev_neg <= 1'b0;
        end else if (state == ST_ARMED && i_sample_valid) begin
            prev_neg <= i_sample[SAMPLE_WIDTH-1];
        end
    end
`else
    assign trigger_hit = 1'b0;
`endif

    // A CTRL write in the same cycle as a sample pre-empts capture of that sample.
    assign sample_taken = i_sample_valid && !ctrl_arm && !ctrl_abort &&
                          ((state == ST_CAPTURING) || trigger_hit);
    assign store        = sample_taken && (decim_cnt == '0);
    assign last_store   = store && (count == LAST_COUNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ctrl_abort) begin
            state_next = ST_IDLE;
        end else if (ctrl_arm) begin
            state_next = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
                    if (trigger_hit || ctrl_force) begin
                        state_next = ST_CAPTURING;
                    end
`else
                    state_next = ST_CAPTURING;
`endif
                end
                ST_CAPTURING: begin
                    if (last_store) begin
                        state_next = ST_DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            decim_reg     <= '0;
            decim_latched <= '0;
            decim_cnt     <= '0;
            o_wb_ack      <= 1'b0;
            o_wb_stall    <= 1'b0;
            o_wb_data     <= 32'd0;
            o_irq         <= 1'b0;
        end else begin
            o_wb_ack   <= accept;
            o_wb_stall <= rd_data_req;
            o_irq      <= last_store;

            if (accept && !i_wb_we) begin
                case (i_wb_addr)
                    ADDR_STATUS: o_wb_data <= pack_status(state, state == ST_DONE, 16'(count));
                    ADDR_DECIM:  o_wb_data <= 32'(decim_reg);
                    ADDR_DATA:   o_wb_data <= 32'($signed(ram_q));
                    default:     o_wb_data <= 32'd0;
                endcase
            end

            if (accept && i_wb_we && (i_wb_addr == ADDR_DECIM)) begin
                decim_reg <= i_wb_data[DECIM_WIDTH-1:0];
            end

            if (ctrl_arm) begin
                count         <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                decim_cnt     <= '0;
                decim_latched <= decim_reg;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                    count  <= count + COUNT_WIDTH'(1);
                end
                if (sample_taken) begin
                    decim_cnt <= (decim_cnt == decim_latched) ? '0
                                                              : decim_cnt + DECIM_WIDTH'(1);
                end
                // Read pointer bump; the stall cycle lets ram_q refill from the new address.
                if (rd_data_req) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
            end
        end
    end

    assign o_busy = (state == ST_ARMED) || (state == ST_CAPTURING);

    sample_capture_ram #(
        .WIDTH      (SAMPLE_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data (i_sample),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_sample_capture_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_sample_capture_wb_slave : directed self-checking bench for the capture buffer
// Revision                   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sample_capture_wb_slave;

    localparam int SW = 17;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DECIM  = 2'd2;
    localparam logic [1:0] A_DATA   = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [1:0]    addr;
    logic [31:0]   wdata;
    logic          ack, stall;
    logic [31:0]   rdata;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          busy, irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_val;
    logic        rd_ack, rd_stall;
    int          irq_cnt;

    always #5 clk = ~clk;

    sample_capture_wb_slave dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_wb_cyc       (cyc),
        .i_wb_stb       (stb),
        .i_wb_we        (we),
        .i_wb_addr      (addr),
        .i_wb_data      (wdata),
        .o_wb_ack       (ack),
        .o_wb_stall     (stall),
        .o_wb_data      (rdata),
        .i_sample       (sample),
        .i_sample_valid (sample_valid),
        .o_busy         (busy),
        .o_irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a negative clock edge.
    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        rd_ack = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        @(negedge clk);
        rd_val = rdata; rd_ack = ack; rd_stall = stall;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        wb_read(a);
        check(tag, rd_val, exp);
        check({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
    endtask

    task automatic arm_and_start();
        wb_write(A_CTRL, 32'h1);
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        wb_write(A_CTRL, 32'h4);
`else
        @(negedge clk);
`endif
    endtask

    task automatic feed(input int v);
        sample = SW'(v); sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        sample = '0; sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ack",   {31'd0, ack},   32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata,          32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_irq",   {31'd0, irq},   32'd0);
        read_check("rst_status", A_STATUS, 32'd0);
        read_check("rst_decim",  A_DECIM,  32'd0);

        // Full capture, DECIM=0, ramp every cycle
        arm_and_start();
        check("cap_busy", {31'd0, busy}, 32'd1);
        irq_cnt = 0;
        for (int i = 0; i < 1030; i++) begin
            sample = SW'(i < 1024 ? i : 0);
            sample_valid = (i < 1024);
            @(negedge clk);
            if (irq) irq_cnt++;
        end
        sample_valid = 1'b0;
        check("irq_pulses", irq_cnt, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        read_check("done_status", A_STATUS, 32'h0400_0007);
        for (int i = 0; i < 1024; i++) begin
            wb_read(A_DATA);
            check("ramp_data", rd_val, 32'(i));
            check("ramp_stall", {31'd0, rd_stall}, 32'd1);
        end
        read_check("wrap_data", A_DATA, 32'd0);

        // Decimation by 3
        wb_write(A_DECIM, 32'd2);
        read_check("decim_rb", A_DECIM, 32'd2);
        arm_and_start();
        for (int i = 0; i < 3080; i++) begin
            sample = SW'(i);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        read_check("decim_status", A_STATUS, 32'h0400_0007);
        for (int i = 0; i < 8; i++) begin
            read_check("decim_data", A_DATA, 32'(3 * i));
        end

        // Sign extension, abort at count 100
        wb_write(A_DECIM, 32'd0);
        arm_and_start();
        feed(-5);
        feed(65535);
        for (int i = 2; i < 100; i++) feed(i);
        wb_write(A_CTRL, 32'h2);
        read_check("abort_status", A_STATUS, 32'h0064_0000);
        read_check("ctrl_read",    A_CTRL,   32'd0);
        read_check("neg_data",     A_DATA,   32'hFFFF_FFFB);
        read_check("max_data",     A_DATA,   32'h0000_FFFF);
        wb_write(A_CTRL, 32'h3);
        read_check("armabort_status", A_STATUS, 32'h0064_0000);
        wb_write(A_CTRL, 32'h1);
        read_check("rearm_status", A_STATUS, 32'h0000_0001);
        wb_write(A_CTRL, 32'h2);

        // Trigger behaviour
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        wb_write(A_CTRL, 32'h1);
`else
        arm_and_start();
`endif
        feed(-3); feed(-1); feed(2); feed(5);
        wb_write(A_CTRL, 32'h2);
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        read_check("trig_first",  A_DATA, 32'd2);
        read_check("trig_second", A_DATA, 32'd5);
`else
        read_check("trig_first",  A_DATA, 32'hFFFF_FFFD);
        read_check("trig_second", A_DATA, 32'hFFFF_FFFF);
`endif

        // Reset in mid-capture
        wb_write(A_DECIM, 32'd7);
        arm_and_start();
        feed(1); feed(2); feed(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        read_check("mrst_status", A_STATUS, 32'd0);
        read_check("mrst_decim",  A_DECIM,  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
